// File: rtl/game_pkg.sv
// Shared types and constants for the turn arbiter: FSM state encoding,
// player limits and a helper that picks the lowest-numbered presser.
package game_pkg;

  localparam int MAX_PLAYERS = 6;
  localparam int PLAYER_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Lowest set bit as a 1-based player id; 0 when no bit is set.
  function automatic logic [PLAYER_ID_W-1:0] lowest_id(input logic [MAX_PLAYERS-1:0] v);
    logic [PLAYER_ID_W-1:0] id;
    id = '0;
    for (int k = MAX_PLAYERS - 1; k >= 0; k--) begin
      if (v[k]) id = PLAYER_ID_W'(k + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-stage synchronizer plus registered rising-edge detector for raw buttons.
// A bit only produces edges after it has been seen low once the pipeline holds real samples.
module btn_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] press
);

  localparam int FW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;

  logic [W-1:0]  sync_q [STAGES];
  logic [W-1:0]  prev_q;
  logic [W-1:0]  armed_q;
  logic [FW-1:0] fill_q;
  logic          fill_done;
  logic [W-1:0]  sync_last;

  assign sync_last = sync_q[STAGES-1];
  assign fill_done = (fill_q == FW'(STAGES));

  // Buttons held through reset stay disarmed until they are released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
      press   <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (!fill_done) fill_q <= fill_q + FW'(1);
      prev_q <= sync_last;
      if (fill_done) armed_q <= armed_q | ~sync_last;
      press <= fill_done ? (sync_last & ~prev_q & armed_q) : '0;
    end
  end

endmodule

// File: rtl/turn_arbiter.sv
// Turn-based game arbiter: players press in rotation; an out-of-turn press or
// a turn timeout ends the game and names the loser.
module turn_arbiter
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2,
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             num_players,
  input  logic [MAX_PLAYERS-1:0] btn,
  output logic [PLAYER_ID_W-1:0] turn,
  output logic                   move_valid,
  output logic [PLAYER_ID_W-1:0] move_player,
  output logic                   over,
  output logic [PLAYER_ID_W-1:0] loser,
  output logic [TW-1:0]          timer,
  output state_e                 state
);

  logic [MAX_PLAYERS-1:0] press;
  logic [MAX_PLAYERS-1:0] mask;
  logic [MAX_PLAYERS-1:0] e_m;
  logic [MAX_PLAYERS-1:0] own;
  logic [MAX_PLAYERS-1:0] other;
  logic [PLAYER_ID_W-1:0] n_q;

  state_e                 state_n;
  logic [PLAYER_ID_W-1:0] turn_n, move_player_n, loser_n, n_n;
  logic                   move_valid_n, over_n;
  logic [TW-1:0]          timer_n;

  btn_sync #(.W(MAX_PLAYERS), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (btn),
    .press (press)
  );

  always_comb begin
    for (int k = 0; k < MAX_PLAYERS; k++) mask[k] = (int'(n_q) > k);
  end

  assign e_m   = press & mask;
  assign own   = (turn != '0) ? (MAX_PLAYERS'(1) << (turn - PLAYER_ID_W'(1))) : '0;
  assign other = e_m & ~own;

  always_comb begin
    state_n       = state;
    turn_n        = turn;
    move_valid_n  = 1'b0;
    move_player_n = '0;
    over_n        = over;
    loser_n       = loser;
    timer_n       = timer;
    n_n           = n_q;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (state == ST_IDLE) timer_n = '0;
        if (start) begin
          state_n = ST_PLAY;
          turn_n  = PLAYER_ID_W'(1);
          timer_n = '0;
          loser_n = '0;
          over_n  = 1'b0;
          n_n     = (num_players >= 3'd2 && num_players <= 3'd6) ? num_players : 3'd6;
        end
      end
      ST_PLAY: begin
        // Any out-of-turn press wins over a simultaneous legal press and over the timeout.
        if (other != '0) begin
          state_n = ST_OVER;
          over_n  = 1'b1;
          loser_n = lowest_id(other);
          turn_n  = '0;
        end else if (e_m == own && own != '0) begin
          move_valid_n  = 1'b1;
          move_player_n = turn;
          turn_n        = (turn == n_q) ? PLAYER_ID_W'(1) : turn + PLAYER_ID_W'(1);
          timer_n       = '0;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = ST_OVER;
          over_n  = 1'b1;
          loser_n = turn;
          turn_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        turn_n  = '0;
        over_n  = 1'b0;
        loser_n = '0;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      turn        <= '0;
      move_valid  <= 1'b0;
      move_player <= '0;
      over        <= 1'b0;
      loser       <= '0;
      timer       <= '0;
      n_q         <= 3'd6;
    end else begin
      state       <= state_n;
      turn        <= turn_n;
      move_valid  <= move_valid_n;
      move_player <= move_player_n;
      over        <= over_n;
      loser       <= loser_n;
      timer       <= timer_n;
      n_q         <= n_n;
    end
  end

endmodule

// File: tb/tb_turn_arbiter.sv
// Self-checking bench for turn_arbiter: rotation, forfeits, timeout, masking and reset behaviour.
module tb_turn_arbiter;
  import game_pkg::*;

  localparam int TO = 16;
  localparam int SS = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] num_players;
  logic [5:0] btn;
  logic [2:0] turn;
  logic       move_valid;
  logic [2:0] move_player;
  logic       over;
  logic [2:0] loser;
  logic [3:0] timer;
  state_e     state;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  turn_arbiter #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_players (num_players),
    .btn         (btn),
    .turn        (turn),
    .move_valid  (move_valid),
    .move_player (move_player),
    .over        (over),
    .loser       (loser),
    .timer       (timer),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every move_valid must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && move_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_move: got player %0d, required no move_valid", move_player);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (move_player !== e) begin
          errors++;
          $display("FAIL move_player: got %0d required %0d", move_player, e);
        end
      end
    end
  end

  // driver tasks
  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; btn = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic start_game(input logic [2:0] n);
    start = 1'b1; num_players = n;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (turn !== 3'd1 || over !== 1'b0 || timer !== 4'd0 || loser !== 3'd0 || state !== ST_PLAY) begin
      errors++;
      $display("FAIL start_game: got turn=%0d over=%0d timer=%0d loser=%0d state=%0d required 1 0 0 0 %0d",
               turn, over, timer, loser, state, ST_PLAY);
    end
  endtask

  task automatic press(input int p, input bit legal);
    if (legal) exp_q.push_back(3'(p));
    btn[p-1] = 1'b1;
    repeat (4) @(negedge clk);
    btn[p-1] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; btn = '0; num_players = 3'd3;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (state !== ST_IDLE || turn !== 3'd0 || over !== 1'b0 || loser !== 3'd0 || timer !== 4'd0 ||
        move_valid !== 1'b0 || move_player !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d turn=%0d over=%0d loser=%0d timer=%0d mv=%0d mp=%0d required all 0",
               state, turn, over, loser, timer, move_valid, move_player);
    end
    press(1, 1'b0);
    checks++;
    if (state !== ST_IDLE || timer !== 4'd0) begin
      errors++;
      $display("FAIL idle_press: got state=%0d timer=%0d required %0d 0", state, timer, ST_IDLE);
    end
    start_game(3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (turn !== 3'd0 || state !== ST_IDLE || timer !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got turn=%0d state=%0d timer=%0d required 0 %0d 0", turn, state, timer, ST_IDLE);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rotation();
    apply_reset();
    start_game(3);
    press(1, 1'b1);
    press(2, 1'b1);
    press(3, 1'b1);
    press(1, 1'b1);
    checks++;
    if (turn !== 3'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rotation: got turn=%0d pending=%0d required turn 2 pending 0", turn, exp_q.size());
    end
    start = 1'b1; num_players = 3'd5;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++;
    if (turn !== 3'd2 || state !== ST_PLAY) begin
      errors++;
      $display("FAIL start_in_play: got turn=%0d state=%0d required 2 %0d", turn, state, ST_PLAY);
    end
  endtask

  task automatic test_out_of_turn();
    apply_reset();
    start_game(6);
    press(4, 1'b0);
    checks++;
    if (over !== 1'b1 || loser !== 3'd4 || turn !== 3'd0 || state !== ST_OVER) begin
      errors++;
      $display("FAIL out_of_turn: got over=%0d loser=%0d turn=%0d required 1 4 0", over, loser, turn);
    end
    apply_reset();
    start_game(6);
    btn = 6'b000011;
    repeat (4) @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (over !== 1'b1 || loser !== 3'd2 || turn !== 3'd0) begin
      errors++;
      $display("FAIL simultaneous: got over=%0d loser=%0d turn=%0d required 1 2 0", over, loser, turn);
    end
    // restart from OVER, then a press from a player beyond N is masked
    start_game(2);
    press(5, 1'b0);
    checks++;
    if (turn !== 3'd1 || over !== 1'b0) begin
      errors++;
      $display("FAIL masked_player: got turn=%0d over=%0d required 1 0", turn, over);
    end
  endtask

  task automatic test_timeout();
    int  k;
    bit  seen;
    apply_reset();
    start_game(3);
    exp_q.push_back(3'd1);
    btn[0] = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (turn == 3'd2) seen = 1'b1;
    end
    btn[0] = 1'b0;
    checks++;
    if (!seen || timer !== 4'd0) begin
      errors++;
      $display("FAIL turn2_begin: got seen=%0d timer=%0d required 1 0", seen, timer);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (over !== 1'b0 || timer !== 4'd15) begin
      errors++;
      $display("FAIL pre_timeout: got over=%0d timer=%0d required 0 15", over, timer);
    end
    @(negedge clk);
    checks++;
    if (over !== 1'b1 || loser !== 3'd2 || turn !== 3'd0 || timer !== 4'd15) begin
      errors++;
      $display("FAIL timeout: got over=%0d loser=%0d turn=%0d timer=%0d required 1 2 0 15", over, loser, turn, timer);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (timer !== 4'd15 || over !== 1'b1) begin
      errors++;
      $display("FAIL timer_hold: got timer=%0d over=%0d required 15 1", timer, over);
    end
  endtask

  task automatic test_out_of_range_n();
    apply_reset();
    start_game(7);
    for (int p = 1; p <= 5; p++) press(p, 1'b1);
    checks++;
    if (turn !== 3'd6) begin
      errors++;
      $display("FAIL n7_turn6: got turn=%0d required 6", turn);
    end
    press(6, 1'b1);
    checks++;
    if (turn !== 3'd1 || over !== 1'b0) begin
      errors++;
      $display("FAIL n7_wrap: got turn=%0d over=%0d required 1 0", turn, over);
    end
  endtask

  task automatic test_reset_held();
    apply_reset();
    start_game(3);
    exp_q.push_back(3'd1);
    btn[0] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_game(3);
    repeat (4) @(negedge clk);
    checks++;
    if (turn !== 3'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_after_reset: got turn=%0d pending=%0d required 1 0", turn, exp_q.size());
    end
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(3'd1);
    btn[0] = 1'b1;
    repeat (4) @(negedge clk);
    btn[0] = 1'b0;
    checks++;
    if (turn !== 3'd2) begin
      errors++;
      $display("FAIL repress_after_reset: got turn=%0d required 2", turn);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; btn = '0; num_players = 3'd3;
    test_reset();
    test_rotation();
    test_out_of_turn();
    test_timeout();
    test_out_of_range_n();
    test_reset_held();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_moves: got %0d outstanding required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_arbiter.md
TURN_ARBITER -- requirements
Module: turn_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, cycles allowed per turn before the turn player forfeits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on raw buttons.
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; starts a new game when in IDLE or OVER.
REQ-006 num_players  input  3  active player count, sampled on start.
REQ-007 btn  input  6  raw asynchronous active-high player buttons, bit k = player k+1.
REQ-008 turn  output  3  player whose turn it is (1..6); 0 when not in PLAY.
REQ-009 move_valid  output  1  one-cycle pulse: turn player pressed legally.
REQ-010 move_player  output  3  player id qualified by move_valid.
REQ-011 over  output  1  high while in OVER.
REQ-012 loser  output  3  losing player id, valid while over=1; 0 otherwise.
REQ-013 timer  output  log2(TIMEOUT_CYCLES)  cycles elapsed in current turn.

Function
REQ-014 Each btn bit SHALL pass through SYNC_STAGES flops, then a registered rising-edge detector; press edge e[k] asserts exactly one cycle, SYNC_STAGES+1 cycles after btn rises.
REQ-015 Held buttons SHALL produce no further edges; a new edge requires btn low for at least one synchronized cycle.
REQ-016 FSM states: IDLE, PLAY, OVER; all outputs registered.
REQ-017 IDLE/OVER -> PLAY on start=1: turn=1, timer=0, loser=0, over=0, N latched from num_players.
REQ-018 num_players values outside 2..6 SHALL latch N=6.
REQ-019 Edges from players > N SHALL be masked in every state; edges in IDLE/OVER SHALL be ignored.
REQ-020 PLAY, masked edge vector e: if any bit other than turn-1 is set -> OVER, loser = lowest-index out-of-turn presser, no move_valid, even when the turn player pressed in the same cycle.
REQ-021 PLAY, e == only bit turn-1 -> move_valid=1, move_player=turn next cycle; turn advances by 1, N wraps to 1; timer clears.
REQ-022 PLAY, no edge, timer == TIMEOUT_CYCLES-1 -> OVER, loser=turn.
REQ-023 Edge and timeout in the same cycle: edge rules (REQ-020/021) SHALL take priority.
REQ-024 timer SHALL increment each PLAY cycle, hold in OVER, read 0 in IDLE.
REQ-025 start held high in PLAY SHALL have no effect.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, turn=0, move_valid=0, move_player=0, over=0, loser=0, timer=0, all synchronizer and edge flops to 0.
REQ-027 Reset mid-game SHALL discard the game; no move_valid within SYNC_STAGES+1 cycles after release even with buttons held.

Structure
REQ-028 Shared package game_pkg SHALL hold the state enum, MAX_PLAYERS=6, PLAYER_ID_W=3.
REQ-029 Synchronizer plus edge detector SHALL be one sub-module, btn_sync, instantiated once at width 6.

Verification
REQ-030 start, N=3, players 1,2,3,1 press in turn -> four move_valid pulses with move_player 1,2,3,1; turn ends at 2.
REQ-031 N=6, turn=1, player 4 presses -> over=1, loser=4, turn=0, no move_valid.
REQ-032 turn=1, players 1 and 2 press in the same synchronized cycle -> over=1, loser=2, no move_valid.
REQ-033 TIMEOUT_CYCLES=16, turn=2, no press -> over=1, loser=2 sixteen cycles after the turn began; timer holds 15.
REQ-034 N=2, player 5 presses -> ignored, turn unchanged; num_players=7 on start -> player 6 gets a turn after player 5.
REQ-035 reset asserted mid-game with btn[0] held, then released and start -> no move_valid until btn[0] falls and rises again.
